// File: rtl/sram_mp_ctrl.sv
// sram_mp_ctrl: NUM_CH-way arbiter, registered issue stage and read-tag FIFO.
// Optional: define SRAM_MP_CTRL_PRIO0_EN to give channel 0 fixed top priority.
module sram_mp_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int BE_W    = DATA_W / 8,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic [NUM_CH-1:0]        ch_req,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH-1:0]        ch_rd,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*BE_W-1:0]   ch_be,
  input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
  output logic [NUM_CH-1:0]        ch_rd_data_vld,
  output logic [DATA_W-1:0]        ch_rd_data,
  output logic                     mem_req,
  input  logic                     mem_ready,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [BE_W-1:0]          mem_be,
  output logic [DATA_W-1:0]        mem_wr_data,
  input  logic                     mem_rd_data_vld,
  input  logic [DATA_W-1:0]        mem_rd_data,
  output logic                     rd_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [IDX_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [IDX_W-1:0]  r_tag [MAX_OUT];

  logic              r_mem_req;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BE_W-1:0]   r_mem_be;
  logic [DATA_W-1:0] r_mem_wd;

  logic [NUM_CH-1:0] r_rd_vld;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_err;

  logic              w_stage_free;
  logic              w_full;
  logic              w_found;
  logic              w_xfer;
  logic              w_push;
  logic              w_pop;
  logic              w_orphan;
  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_grant;
  logic [IDX_W-1:0]  w_gidx;
  logic [IDX_W-1:0]  w_cand;
  logic [IDX_W-1:0]  w_nxt_ptr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [BE_W-1:0]   w_sel_be;
  logic [DATA_W-1:0] w_sel_wd;
  logic              w_sel_rd;

  assign w_stage_free = !r_mem_req || mem_ready;
  assign w_full       = (r_cnt == CNT_W'(MAX_OUT));

  // Full uses the registered count, so a same-cycle pop never unmasks reads.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_elig[i] = ch_req[i] && (!ch_rd[i] || !w_full);
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
`ifdef SRAM_MP_CTRL_PRIO0_EN
    if (w_elig[0]) begin
      w_found = 1'b1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % NUM_CH);
      if (!w_found && (w_cand != '0) && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
`else
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % NUM_CH);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
`endif
  end

  always_comb begin
    w_grant = '0;
    if (w_found && w_stage_free) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign ch_ready  = reset_ ? w_grant : '0;
  assign w_xfer    = w_found && w_stage_free;
  assign w_nxt_ptr = (w_gidx == IDX_W'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;

  assign w_sel_rd   = ch_rd[w_gidx];
  assign w_sel_addr = ch_addr[w_gidx*ADDR_W +: ADDR_W];
  assign w_sel_be   = ch_be[w_gidx*BE_W +: BE_W];
  assign w_sel_wd   = ch_wr_data[w_gidx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_ptr <= '0;
    end else begin
`ifdef SRAM_MP_CTRL_PRIO0_EN
      if (w_xfer && (w_gidx != '0)) begin
        r_ptr <= w_nxt_ptr;
      end
`else
      if (w_xfer) begin
        r_ptr <= w_nxt_ptr;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_mem_req  <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_be   <= '0;
      r_mem_wd   <= '0;
    end else if (w_xfer) begin
      r_mem_req  <= 1'b1;
      r_mem_rd   <= w_sel_rd;
      r_mem_addr <= w_sel_addr;
      r_mem_be   <= w_sel_be;
      r_mem_wd   <= w_sel_wd;
    end else if (mem_ready) begin
      r_mem_req  <= 1'b0;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign mem_be      = r_mem_be;
  assign mem_wr_data = r_mem_wd;

  // A read counts as outstanding from the moment it enters the stage.
  assign w_push   = w_xfer && w_sel_rd;
  assign w_pop    = mem_rd_data_vld && (r_cnt != '0);
  assign w_orphan = mem_rd_data_vld && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_tag[r_wr_ptr] <= w_gidx;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_rd_vld  <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rd_vld <= '0;
      if (w_pop) begin
        r_rd_vld[r_tag[r_rd_ptr]] <= 1'b1;
        r_rd_data <= mem_rd_data;
      end
      if (w_orphan) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ch_rd_data_vld = r_rd_vld;
  assign ch_rd_data     = r_rd_data;
  assign rd_err         = r_err;

endmodule

// File: tb/tb_sram_mp_ctrl.sv
// tb_sram_mp_ctrl: vector table, directed corner sequences and random traffic
// against a queue-based reference model of sram_mp_ctrl.
module tb_sram_mp_ctrl;

  localparam int NUM_CH  = 4;
  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 16;
  localparam int BE_W    = 2;
  localparam int MAX_OUT = 4;

  logic                     clk = 1'b0;
  logic                     reset_;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        ch_rd;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*BE_W-1:0]   ch_be;
  logic [NUM_CH*DATA_W-1:0] ch_wr_data;
  logic [NUM_CH-1:0]        ch_rd_data_vld;
  logic [DATA_W-1:0]        ch_rd_data;
  logic                     mem_req;
  logic                     mem_ready;
  logic                     mem_rd;
  logic [ADDR_W-1:0]        mem_addr;
  logic [BE_W-1:0]          mem_be;
  logic [DATA_W-1:0]        mem_wr_data;
  logic                     mem_rd_data_vld;
  logic [DATA_W-1:0]        mem_rd_data;
  logic                     rd_err;

  always #5 clk = ~clk;

  sram_mp_ctrl #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk            (clk),
    .reset_         (reset_),
    .ch_req         (ch_req),
    .ch_ready       (ch_ready),
    .ch_rd          (ch_rd),
    .ch_addr        (ch_addr),
    .ch_be          (ch_be),
    .ch_wr_data     (ch_wr_data),
    .ch_rd_data_vld (ch_rd_data_vld),
    .ch_rd_data     (ch_rd_data),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wr_data    (mem_wr_data),
    .mem_rd_data_vld(mem_rd_data_vld),
    .mem_rd_data    (mem_rd_data),
    .rd_err         (rd_err)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: transaction-level state
  int                m_ptr;
  int                m_q[$];
  logic              m_req;
  logic              m_rd;
  logic [ADDR_W-1:0] m_addr;
  logic [BE_W-1:0]   m_be;
  logic [DATA_W-1:0] m_wd;
  logic [NUM_CH-1:0] m_vld;
  logic [DATA_W-1:0] m_data;
  logic              m_err;

  task automatic model_reset();
    m_ptr  = 0;
    m_q.delete();
    m_req  = 0;
    m_rd   = 0;
    m_addr = '0;
    m_be   = '0;
    m_wd   = '0;
    m_vld  = '0;
    m_data = '0;
    m_err  = 0;
  endtask

  function automatic bit ok(input int c, input bit full);
    return ch_req[c] && !(ch_rd[c] && full);
  endfunction

  function automatic int pick();
    bit full;
    int start;
    full = (m_q.size() >= MAX_OUT);
    if (m_req && !mem_ready) return -1;
`ifdef SRAM_MP_CTRL_PRIO0_EN
    if (ok(0, full)) return 0;
    start = (m_ptr == 0) ? 1 : m_ptr;
    for (int k = 0; k < NUM_CH - 1; k++) begin
      int c;
      c = 1 + (start - 1 + k) % (NUM_CH - 1);
      if (ok(c, full)) return c;
    end
`else
    start = m_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (start + k) % NUM_CH;
      if (ok(c, full)) return c;
    end
`endif
    return -1;
  endfunction

  task automatic step_chk();
    int g;
    logic [NUM_CH-1:0] er;
    @(negedge clk);
    g  = pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ready", 64'(ch_ready), 64'(er));
    chk("mem_req", 64'(mem_req), 64'(m_req));
    chk("mem_fields", 64'({mem_rd, mem_addr, mem_be, mem_wr_data}),
        64'({m_rd, m_addr, m_be, m_wd}));
    chk("rd_vld", 64'(ch_rd_data_vld), 64'(m_vld));
    chk("rd_data", 64'(ch_rd_data), 64'(m_data));
    chk("rd_err", 64'(rd_err), 64'(m_err));
  endtask

  task automatic step_adv();
    int g;
    int t;
    @(posedge clk);
    g = pick();
    m_vld = '0;
    if (mem_rd_data_vld) begin
      if (m_q.size() == 0) begin
        m_err = 1;
      end else begin
        t = m_q.pop_front();
        m_vld[t] = 1'b1;
        m_data = mem_rd_data;
      end
    end
    if (g >= 0) begin
      m_req  = 1;
      m_rd   = ch_rd[g];
      m_addr = ch_addr[g*ADDR_W +: ADDR_W];
      m_be   = ch_be[g*BE_W +: BE_W];
      m_wd   = ch_wr_data[g*DATA_W +: DATA_W];
      if (ch_rd[g]) m_q.push_back(g);
`ifdef SRAM_MP_CTRL_PRIO0_EN
      if (g != 0) m_ptr = (g + 1) % NUM_CH;
`else
      m_ptr = (g + 1) % NUM_CH;
`endif
    end else if (mem_ready) begin
      m_req = 0;
    end
    #1;
  endtask

  task automatic cycle();
    step_chk();
    step_adv();
  endtask

  task automatic set_ch(input int i, input bit rq, input bit rd,
                        input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] b,
                        input logic [DATA_W-1:0] d);
    ch_req[i] = rq;
    ch_rd[i]  = rd;
    ch_addr[i*ADDR_W +: ADDR_W] = a;
    ch_be[i*BE_W +: BE_W]       = b;
    ch_wr_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_in();
    ch_req = '0;
    ch_rd  = '0;
    mem_ready = 1'b1;
    mem_rd_data_vld = 1'b0;
    mem_rd_data = '0;
  endtask

  task automatic idle(input int n);
    clear_in();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    #2;
    chk("rst_ready", 64'(ch_ready), 64'(0));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_fields", 64'({mem_rd, mem_addr, mem_be, mem_wr_data}), 64'(0));
    chk("rst_vld", 64'(ch_rd_data_vld), 64'(0));
    chk("rst_data", 64'(ch_rd_data), 64'(0));
    chk("rst_err", 64'(rd_err), 64'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  typedef struct {
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] rd;
    logic              mrdy;
    logic [NUM_CH-1:0] er;
    logic              emr;
  } vec_t;

  vec_t tbl[$];
  int   acc;

  initial begin
    reset_ = 1'b1;
    ch_addr = '0;
    ch_be = '0;
    ch_wr_data = '0;
    clear_in();
    ch_req = 4'b1111;
    model_reset();
    #1;
    do_reset();

`ifdef SRAM_MP_CTRL_PRIO0_EN
    tbl.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0});
    tbl.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1});
    tbl.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1});
    tbl.push_back('{4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b1});
    tbl.push_back('{4'b1110, 4'b0000, 1'b1, 4'b0100, 1'b1});
    tbl.push_back('{4'b1110, 4'b0000, 1'b1, 4'b1000, 1'b1});
    tbl.push_back('{4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0});
`else
    tbl.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0});
    tbl.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1});
    tbl.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1});
    tbl.push_back('{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1});
    tbl.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1});
    tbl.push_back('{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1});
    tbl.push_back('{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1});
    tbl.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1});
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0});
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      set_ch(i, 1'b0, 1'b0, ADDR_W'(32'h100 + i), BE_W'(i), DATA_W'(32'hC0 + i));
    end
    foreach (tbl[i]) begin
      ch_req = tbl[i].req;
      ch_rd  = tbl[i].rd;
      mem_ready = tbl[i].mrdy;
      step_chk();
      chk($sformatf("tbl%0d_ready", i), 64'(ch_ready), 64'(tbl[i].er));
      chk($sformatf("tbl%0d_mem_req", i), 64'(mem_req), 64'(tbl[i].emr));
      step_adv();
    end

    // ch2 write stalled by mem_ready low for three cycles
    idle(2);
    set_ch(2, 1'b1, 1'b0, 18'h1234, 2'b01, 16'hBEEF);
    step_chk();
    chk("wr_grant", 64'(ch_ready), 64'(4'b0100));
    step_adv();
    acc = 0;
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_chk();
      chk("wr_stall_ready", 64'(ch_ready), 64'(0));
      chk("wr_stall_issue", 64'({mem_req, mem_rd, mem_addr, mem_be, mem_wr_data}),
          64'({1'b1, 1'b0, 18'h1234, 2'b01, 16'hBEEF}));
      if (mem_req && mem_ready) acc++;
      step_adv();
    end
    ch_req = '0;
    mem_ready = 1'b1;
    step_chk();
    if (mem_req && mem_ready) acc++;
    step_adv();
    step_chk();
    chk("wr_accepted_once", 64'(acc), 64'(1));
    chk("wr_done", 64'(mem_req), 64'(0));
    step_adv();

    // ch1 read then ch3 read, returns routed back in order
    idle(1);
    set_ch(1, 1'b1, 1'b1, 18'h10, 2'b11, 16'h0);
    cycle();
    ch_req = '0;
    set_ch(3, 1'b1, 1'b1, 18'h20, 2'b11, 16'h0);
    cycle();
    ch_req = '0;
    ch_rd = '0;
    cycle();
    mem_rd_data_vld = 1'b1;
    mem_rd_data = 16'hAAAA;
    step_chk();
    chk("ret0_not_yet", 64'(ch_rd_data_vld), 64'(0));
    step_adv();
    mem_rd_data = 16'h5555;
    step_chk();
    chk("ret0_vld", 64'(ch_rd_data_vld), 64'(4'b0010));
    chk("ret0_data", 64'(ch_rd_data), 64'(16'hAAAA));
    step_adv();
    mem_rd_data_vld = 1'b0;
    mem_rd_data = 16'h0;
    step_chk();
    chk("ret1_vld", 64'(ch_rd_data_vld), 64'(4'b1000));
    chk("ret1_data", 64'(ch_rd_data), 64'(16'h5555));
    step_adv();
    step_chk();
    chk("ret_hold", 64'({ch_rd_data_vld, ch_rd_data}), 64'({4'b0000, 16'h5555}));
    step_adv();

    // ch0 floods reads: FIFO full masks reads, writes still pass
    clear_in();
    for (int k = 0; k < 5; k++) begin
      set_ch(0, 1'b1, 1'b1, ADDR_W'(32'h40 + k), 2'b11, 16'h0);
      step_chk();
      chk($sformatf("flood%0d", k), 64'(ch_ready),
          64'((k < MAX_OUT) ? 4'b0001 : 4'b0000));
      step_adv();
    end
    set_ch(1, 1'b1, 1'b0, 18'h77, 2'b10, 16'h1357);
    step_chk();
    chk("full_write_ok", 64'(ch_ready), 64'(4'b0010));
    step_adv();
    ch_req[1] = 1'b0;
    mem_rd_data_vld = 1'b1;
    mem_rd_data = 16'h1111;
    step_chk();
    chk("pop_no_unmask", 64'(ch_ready), 64'(4'b0000));
    step_adv();
    mem_rd_data_vld = 1'b0;
    step_chk();
    chk("fifth_read", 64'(ch_ready), 64'(4'b0001));
    step_adv();
    clear_in();
    mem_rd_data_vld = 1'b1;
    for (int k = 0; k < MAX_OUT; k++) begin
      mem_rd_data = DATA_W'(32'h2000 + k);
      cycle();
    end
    idle(2);

    // return with nothing outstanding
    mem_rd_data_vld = 1'b1;
    mem_rd_data = 16'hDEAD;
    cycle();
    mem_rd_data_vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step_chk();
      chk("orphan_no_vld", 64'(ch_rd_data_vld), 64'(0));
      chk("orphan_err", 64'(rd_err), 64'(1));
      step_adv();
    end
    do_reset();

    // random traffic
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        set_ch(i, 1'($urandom), 1'($urandom), ADDR_W'($urandom),
               BE_W'($urandom), DATA_W'($urandom));
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rd_data_vld = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rd_data = DATA_W'($urandom);
      cycle();
    end

    // reset with reads in flight; later returns are orphans
    clear_in();
    set_ch(2, 1'b1, 1'b1, 18'h3, 2'b11, 16'h0);
    cycle();
    cycle();
    do_reset();
    clear_in();
    mem_rd_data_vld = 1'b1;
    cycle();
    mem_rd_data_vld = 1'b0;
    step_chk();
    chk("post_rst_orphan", 64'({rd_err, ch_rd_data_vld}), 64'({1'b1, 4'b0000}));
    step_adv();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
